rx_transport: RTL and testbench
===============================

# rx_transport

Transport-layer deframer directly downstream of the JESD204B receiver top level. It consumes the lane-aligned, descrambled octet stream and its frame markers: `rx_data_o`, `rx_valid_o`, `rx_sof_o` and `rx_somf_o`. It reassembles complete frames across beats and maps frame octets onto M converters × S samples of 16 bits. It emits one registered sample word per frame, with frame-alignment error reporting.

## Interface
- `L`, 2, number of lanes; must match the receiver.
- `PARALLEL_OCTETS`, 4, octets per lane per beat.
- `DATA_WIDTH`, 32, bits per lane per beat; equals `PARALLEL_OCTETS*8`.
- `F`, 4, octets per frame per lane.
  - Must be a multiple of `PARALLEL_OCTETS`.
  - Must be ≤ 64.
- `M`, 2, converters.
- `S`, 2, samples per converter per frame.
  - Elaboration check: `M*S*2 == L*F`.
- `N`, 14, converter resolution in bits (1..16); used only with the sign-extension feature.
- `clk_i`  in  1  device clock, same clock as the receiver.
- `rst_i`  in  1  asynchronous, active-high reset.
- `rx_data_i`  in  `L*DATA_WIDTH`  lane data.
  - Lane l occupies bits `[l*DATA_WIDTH +: DATA_WIDTH]`.
  - Octet 0, the earliest octet, is in bits `[7:0]` of each lane.
- `rx_valid_i`  in  1  beat valid.
- `rx_sof_i`  in  `PARALLEL_OCTETS`  start-of-frame per octet position.
- `rx_somf_i`  in  `PARALLEL_OCTETS`  start-of-multiframe per octet position.
- `sample_o`  out  `M*S*16`  frame samples; converter m, sample s at bits `[(m*S+s)*16 +: 16]`.
- `sample_valid_o`  out  1  one-cycle pulse per completed frame.
- `somf_o`  out  1  qualifies `sample_valid_o`; the frame began a multiframe.
- `frame_err_o`  out  1  one-cycle pulse on a frame-alignment error.
- `frame_cnt_o`  out  16  completed-frame counter; wraps at 0xFFFF→0.

## Operation
- Derived constants:
  - `BPF = F/PARALLEL_OCTETS`: beats per frame.
  - `bcnt`: beat counter, `$clog2(BPF)` bits, minimum 1.
- Octet mapping:
  - Concatenated frame octet index `c = l*F + o`, where o is the octet index within lane l's frame.
  - Sample index `j = c/2`; converter `m = j/S`, sample `s = j%S`.
  - Even c is the sample MSB, odd c the LSB (big-endian per sample).
- Frame accumulator: `L*F` octets, written at octet offset `bcnt*PARALLEL_OCTETS` per lane.
- State machine:
  - **IDLE**
    - `bcnt=0`.
    - On `rx_valid_i && rx_sof_i[0]`: store the beat at offset 0.
      - `BPF==1`: complete the frame immediately.
      - Otherwise: set `bcnt=1` and go to ASSEMBLE.
    - Beats without `sof[0]` are discarded.
  - **ASSEMBLE**
    - On each valid beat, store it and increment `bcnt`.
    - When the last beat (`bcnt==BPF-1`) is stored: complete the frame, set `bcnt=0`, and stay in ASSEMBLE.
      - In ASSEMBLE, a beat with `bcnt==0` must carry `sof[0]`.
  - **Error handling** (checked in any state, with priority over the normal transitions above):
    - `rx_sof_i[0]` at `bcnt!=0`: pulse `frame_err_o`, discard the partial frame, store the beat as offset 0 of a new frame, set `bcnt=1`.
    - Missing `sof[0]` at `bcnt==0` in ASSEMBLE: pulse `frame_err_o`, go to IDLE, discard the beat.
    - Any `rx_sof_i[k]` or `rx_somf_i[k]` with k≠0: pulse `frame_err_o`, go to IDLE.
  - **Valid drop:** `rx_valid_i` low in ASSEMBLE discards the partial frame and returns to IDLE with no error pulse.
- Frame completion:
  - `sample_o` is loaded from the accumulator, with the last beat taken from the live input.
  - `sample_valid_o` pulses and `frame_cnt_o` increments.
  - `somf_o` is set to the registered `rx_somf_i[0]` captured at the frame's first beat.
- `sample_o` holds its value until the next completion.

## Timing
- Latency: `sample_valid_o` is asserted in the cycle after the clock edge that samples the frame's last beat, i.e. 1 cycle.
- No backpressure: the block accepts one beat per cycle unconditionally.
- Reset values: `sample_o=0`, `sample_valid_o=0`, `somf_o=0`, `frame_err_o=0`, `frame_cnt_o=0`, state IDLE, `bcnt=0`, accumulator 0.
- `rst_i` asserted mid-frame:
  - Clears all state and outputs immediately (asynchronous).
  - After deassertion, the block waits in IDLE for the next `sof[0]`.
- Simultaneous frame completion and error is impossible: the error check has priority and discards the beat's frame-completion role.
- `frame_err_o` and `sample_valid_o` are never high in the same cycle.

## Configuration
- `RX_TRANSPORT_SIGN_EXT_EN`
  - Defined: each 16-bit sample is treated as N-bit data, MSB-justified, with control/tail bits below. Output is `{ {(16-N){d[15]}}, d[15:16-N] }` (arithmetic right shift by 16-N).
  - Undefined: raw 16-bit samples are output and `N` is ignored.

## Test plan
- **Single-beat frame** (`L=2`, `F=4`, `M=2`, `S=2`)
  - Stimulus: lane0=0x44332211, lane1=0x88776655, valid, sof=0b0001.
  - Response, next cycle: `sample_valid_o=1`; samples [0..3] = 0x1122, 0x3344, 0x5566, 0x7788; `frame_cnt_o=1`.
- **Multi-beat frame** (`F=8`, `M=2`, `S=4`)
  - Stimulus: two beats; lane0 = 0x04030201 then 0x08070605.
  - Response: one pulse, one cycle after beat 2; sample0=0x0102, sample3=0x0708.
- **Mid-frame sof** (`F=8`)
  - Stimulus: beat with sof[0] followed by a beat with sof[0].
  - Response: `frame_err_o` pulse one cycle after beat 2, no sample pulse; the next beat completes a frame.
- **Valid drop**
  - Stimulus: `F=8`; valid falls after beat 1, then recovers with sof[0].
  - Response: no error, no sample pulse for the partial frame; the following 2-beat frame produces one pulse.
- **Multiframe flag and misaligned sof**
  - Stimulus: `rx_somf_i=0b0001` on the first beat of a frame.
  - Response: `somf_o=1` with `sample_valid_o`.
  - Stimulus: `rx_sof_i=0b0100`.
  - Response: `frame_err_o` pulse, state IDLE.
- **Sign extension** (`RX_TRANSPORT_SIGN_EXT_EN`, `N=14`)
  - Stimulus: sample octets 0xFF, 0xFC.
  - Response: 0xFFFF.
  - Stimulus: sample octets 0x11, 0x22.
  - Response: 0x0448.
  - Without the macro: 0xFFFC and 0x1122.

Source files
------------

// File: rtl/rx_transport.sv
// JESD204B transport deframer: reassembles L*F-octet frames and maps them to M*S 16-bit samples; outputs registered, 1 cycle after the last beat.
// No backpressure (one beat per cycle). `RX_TRANSPORT_SIGN_EXT_EN selects N-bit MSB-justified sign extension of each sample.
module rx_transport #(
    parameter int L               = 2,
    parameter int PARALLEL_OCTETS = 4,
    parameter int DATA_WIDTH      = 32,
    parameter int F               = 4,
    parameter int M               = 2,
    parameter int S               = 2,
    parameter int N               = 14
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [L*DATA_WIDTH-1:0]      rx_data_i,
    input  logic                         rx_valid_i,
    input  logic [PARALLEL_OCTETS-1:0]   rx_sof_i,
    input  logic [PARALLEL_OCTETS-1:0]   rx_somf_i,
    output logic [M*S*16-1:0]            sample_o,
    output logic                         sample_valid_o,
    output logic                         somf_o,
    output logic                         frame_err_o,
    output logic [15:0]                  frame_cnt_o
);

    localparam int BPF = F / PARALLEL_OCTETS;
    localparam int BW  = (BPF > 1) ? $clog2(BPF) : 1;
    localparam int FW  = L * F * 8;
    localparam int NS  = M * S;
    localparam logic [BW-1:0] BCNT_LAST = BW'(BPF - 1);

    localparam logic [0:0] ST_IDLE     = 1'b0;
    localparam logic [0:0] ST_ASSEMBLE = 1'b1;

    generate
        if (DATA_WIDTH != PARALLEL_OCTETS * 8) begin : g_chk_dw
            $error("DATA_WIDTH must equal PARALLEL_OCTETS*8");
        end
        if ((F % PARALLEL_OCTETS) != 0 || F > 64) begin : g_chk_f
            $error("F must be a multiple of PARALLEL_OCTETS and at most 64");
        end
        if (M * S * 2 != L * F) begin : g_chk_map
            $error("M*S*2 must equal L*F");
        end
        if (N < 1 || N > 16) begin : g_chk_n
            $error("N must be in 1..16");
        end
    endgenerate

    logic [0:0]        state_q, state_d;
    logic [BW-1:0]     bcnt_q, bcnt_d;
    logic              somf_first_q, somf_first_d;
    logic [FW-1:0]     acc_q, acc_wr;
    logic [NS*16-1:0]  sample_q, sample_d;
    logic              valid_q, somf_q, err_q;
    logic [15:0]       cnt_q;

    logic              store, complete, err, misalign, cpl_somf;
    logic [BW-1:0]     wr_beat;

    // Frame control; error cases take priority over normal assembly.
    always_comb begin
        misalign     = 1'b0;
        for (int k = 1; k < PARALLEL_OCTETS; k++) begin
            misalign = misalign | rx_sof_i[k] | rx_somf_i[k];
        end
        state_d      = state_q;
        bcnt_d       = bcnt_q;
        somf_first_d = somf_first_q;
        store        = 1'b0;
        complete     = 1'b0;
        err          = 1'b0;
        wr_beat      = bcnt_q;
        if (rx_valid_i) begin
            if (misalign) begin
                err     = 1'b1;
                state_d = ST_IDLE;
                bcnt_d  = '0;
            end else if (rx_sof_i[0] && bcnt_q != '0) begin
                err          = 1'b1;
                store        = 1'b1;
                wr_beat      = '0;
                bcnt_d       = BW'(1);
                state_d      = ST_ASSEMBLE;
                somf_first_d = rx_somf_i[0];
            end else if (state_q == ST_ASSEMBLE && bcnt_q == '0 && !rx_sof_i[0]) begin
                err     = 1'b1;
                state_d = ST_IDLE;
            end else if (state_q == ST_IDLE) begin
                if (rx_sof_i[0]) begin
                    store        = 1'b1;
                    wr_beat      = '0;
                    somf_first_d = rx_somf_i[0];
                    if (BPF == 1) begin
                        complete = 1'b1;
                    end else begin
                        bcnt_d  = BW'(1);
                        state_d = ST_ASSEMBLE;
                    end
                end
            end else begin
                store = 1'b1;
                if (bcnt_q == '0) begin
                    somf_first_d = rx_somf_i[0];
                end
                if (bcnt_q == BCNT_LAST) begin
                    complete = 1'b1;
                    bcnt_d   = '0;
                end else begin
                    bcnt_d = bcnt_q + 1'b1;
                end
            end
        end else if (state_q == ST_ASSEMBLE) begin
            state_d = ST_IDLE;
            bcnt_d  = '0;
        end
    end

    // Single-beat frames have no earlier beat to have captured the flag.
    assign cpl_somf = (BPF == 1) ? rx_somf_i[0] : somf_first_q;

    always_comb begin
        acc_wr = acc_q;
        for (int l = 0; l < L; l++) begin
            for (int p = 0; p < PARALLEL_OCTETS; p++) begin
                acc_wr[(l*F + int'(wr_beat)*PARALLEL_OCTETS + p)*8 +: 8] = rx_data_i[l*DATA_WIDTH + p*8 +: 8];
            end
        end
    end

    // Even frame octet is the sample MSB.
    always_comb begin
        sample_d = '0;
        for (int j = 0; j < NS; j++) begin
`ifdef RX_TRANSPORT_SIGN_EXT_EN
            sample_d[j*16 +: 16] = 16'($signed({acc_wr[2*j*8 +: 8], acc_wr[(2*j+1)*8 +: 8]}) >>> (16 - N));
`else
            sample_d[j*16 +: 16] = {acc_wr[2*j*8 +: 8], acc_wr[(2*j+1)*8 +: 8]};
`endif
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            bcnt_q       <= '0;
            somf_first_q <= 1'b0;
            acc_q        <= '0;
            sample_q     <= '0;
            valid_q      <= 1'b0;
            somf_q       <= 1'b0;
            err_q        <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            bcnt_q       <= bcnt_d;
            somf_first_q <= somf_first_d;
            if (store) begin
                acc_q <= acc_wr;
            end
            if (complete) begin
                sample_q <= sample_d;
                cnt_q    <= cnt_q + 16'd1;
            end
            valid_q <= complete;
            somf_q  <= complete & cpl_somf;
            err_q   <= err;
        end
    end

    assign sample_o       = sample_q;
    assign sample_valid_o = valid_q;
    assign somf_o         = somf_q;
    assign frame_err_o    = err_q;
    assign frame_cnt_o    = cnt_q;

endmodule

// File: tb/tb_rx_transport.sv
// Bench for rx_transport: two instances (F=4 single-beat, F=8 two-beat) on shared stimulus, checked against a frame-level model.
module tb_rx_transport;

    localparam int NN = 14;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [63:0] rx_data;
    logic        rx_valid;
    logic [3:0]  rx_sof, rx_somf;

    logic [63:0]  s1;
    logic         v1, m1, e1;
    logic [15:0]  c1;
    logic [127:0] s2;
    logic         v2, m2, e2;
    logic [15:0]  c2;

    rx_transport #(.L(2), .PARALLEL_OCTETS(4), .DATA_WIDTH(32), .F(4), .M(2), .S(2), .N(NN)) u1 (
        .clk_i(clk), .rst_i(rst), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
        .rx_sof_i(rx_sof), .rx_somf_i(rx_somf), .sample_o(s1), .sample_valid_o(v1),
        .somf_o(m1), .frame_err_o(e1), .frame_cnt_o(c1));

    rx_transport #(.L(2), .PARALLEL_OCTETS(4), .DATA_WIDTH(32), .F(8), .M(2), .S(4), .N(NN)) u2 (
        .clk_i(clk), .rst_i(rst), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
        .rx_sof_i(rx_sof), .rx_somf_i(rx_somf), .sample_o(s2), .sample_valid_o(v2),
        .somf_o(m2), .frame_err_o(e2), .frame_cnt_o(c2));

    int checks = 0;
    int errors = 0;
    bit run    = 1'b0;

    // Frame-level model: per instance, beats collected so far and whether we are frame-locked.
    int           bpf [2] = '{1, 2};
    bit           locked [2];
    int           nb [2];
    logic [63:0]  beats [2][2];
    bit           fsomf [2];
    logic [127:0] e_sample [2];
    bit           e_valid [2], e_err [2], e_somf [2];
    logic [15:0]  e_cnt [2];

    task automatic chk(string name, logic [127:0] got, logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [15:0] ext(logic [15:0] r);
`ifdef RX_TRANSPORT_SIGN_EXT_EN
        logic signed [15:0] t;
        t = r;
        return 16'(t >>> (16 - NN));
`else
        return r;
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            locked[i] = 0; nb[i] = 0; fsomf[i] = 0;
            beats[i][0] = '0; beats[i][1] = '0;
            e_sample[i] = '0; e_valid[i] = 0; e_err[i] = 0; e_somf[i] = 0; e_cnt[i] = '0;
        end
    endtask

    task automatic model_finish(int i);
        int fo;
        logic [7:0] oct;
        logic [127:0] raw;
        fo  = bpf[i] * 4;
        raw = '0;
        for (int c = 0; c < 2 * fo; c++) begin
            int l, o;
            l = c / fo;
            o = c % fo;
            oct = beats[i][o/4][l*32 + (o%4)*8 +: 8];
            if (c % 2 == 0) raw[(c/2)*16 + 8 +: 8] = oct;
            else            raw[(c/2)*16 +: 8]     = oct;
        end
        e_sample[i] = '0;
        for (int j = 0; j < fo; j++) e_sample[i][j*16 +: 16] = ext(raw[j*16 +: 16]);
        e_valid[i] = 1;
        e_somf[i]  = fsomf[i];
        e_cnt[i]   = e_cnt[i] + 16'd1;
    endtask

    task automatic model_step();
        bit mis;
        mis = (rx_sof[3:1] != 0) || (rx_somf[3:1] != 0);
        for (int i = 0; i < 2; i++) begin
            e_valid[i] = 0; e_err[i] = 0; e_somf[i] = 0;
            if (rx_valid) begin
                if (mis) begin
                    e_err[i] = 1; locked[i] = 0; nb[i] = 0;
                end else if (rx_sof[0] && nb[i] != 0) begin
                    e_err[i] = 1; beats[i][0] = rx_data; fsomf[i] = rx_somf[0]; nb[i] = 1; locked[i] = 1;
                end else if (locked[i] && nb[i] == 0 && !rx_sof[0]) begin
                    e_err[i] = 1; locked[i] = 0;
                end else if (!locked[i]) begin
                    if (rx_sof[0]) begin
                        beats[i][0] = rx_data; fsomf[i] = rx_somf[0];
                        if (bpf[i] == 1) model_finish(i);
                        else begin nb[i] = 1; locked[i] = 1; end
                    end
                end else begin
                    if (nb[i] == 0) fsomf[i] = rx_somf[0];
                    beats[i][nb[i]] = rx_data;
                    if (nb[i] == bpf[i] - 1) begin model_finish(i); nb[i] = 0; end
                    else nb[i] = nb[i] + 1;
                end
            end else if (locked[i]) begin
                locked[i] = 0; nb[i] = 0;
            end
        end
    endtask

    task automatic step(logic [63:0] d, logic v, logic [3:0] sf, logic [3:0] sm);
        rx_data = d; rx_valid = v; rx_sof = sf; rx_somf = sm;
        @(posedge clk);
        model_step();
        #1;
    endtask

    always @(negedge clk) begin
        if (run && !rst) begin
            chk("u1.sample", {64'b0, s1}, e_sample[0]);
            chk("u1.valid", v1, e_valid[0]);
            chk("u1.somf", m1, e_somf[0]);
            chk("u1.err", e1, e_err[0]);
            chk("u1.cnt", c1, e_cnt[0]);
            chk("u2.sample", s2, e_sample[1]);
            chk("u2.valid", v2, e_valid[1]);
            chk("u2.somf", m2, e_somf[1]);
            chk("u2.err", e2, e_err[1]);
            chk("u2.cnt", c2, e_cnt[1]);
        end
    end

    initial begin
        bit ph;
        rst = 1; rx_data = '0; rx_valid = 0; rx_sof = '0; rx_somf = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst.s1", s1, 0);   chk("rst.s2", s2, 0);
        chk("rst.v1", v1, 0);   chk("rst.e2", e2, 0);
        chk("rst.c1", c1, 0);   chk("rst.m2", m2, 0);
        rst = 0;
        run = 1;

        step({32'h88776655, 32'h44332211}, 1, 4'b0001, 4'b0000);
        chk("single.valid", v1, 1);
        chk("single.samples", s1, 64'h7788_5566_3344_1122);
        chk("single.cnt", c1, 1);
        chk("single.u2_latency", v2, 0);

        step({32'h00000000, 32'h2211FCFF}, 1, 4'b0001, 4'b0000);
`ifdef RX_TRANSPORT_SIGN_EXT_EN
        chk("sx.s0", s1[15:0], 16'hFFFF);
        chk("sx.s1", s1[31:16], 16'h0448);
`else
        chk("raw.s0", s1[15:0], 16'hFFFC);
        chk("raw.s1", s1[31:16], 16'h1122);
`endif
        chk("midsof.err", e2, 1);
        chk("midsof.novalid", v2, 0);

        step({$urandom, $urandom}, 1, 4'b0000, 4'b0000);
        chk("midsof.recover", v2, 1);
        chk("idle.nosof_noerr", e1, 0);

        step({32'h0, 32'h04030201}, 1, 4'b0001, 4'b0000);
        chk("mb.beat1_nopulse", v2, 0);
        step({32'h0, 32'h08070605}, 1, 4'b0000, 4'b0000);
        chk("mb.valid", v2, 1);
        chk("mb.sample0", s2[15:0], 16'h0102);
        chk("mb.sample3", s2[63:48], 16'h0708);
        chk("mb.cnt", c2, 2);

        step({$urandom, $urandom}, 1, 4'b0001, 4'b0000);
        step(64'h0, 0, 4'b0000, 4'b0000);
        chk("vdrop.noerr", e2, 0);
        chk("vdrop.novalid", v2, 0);
        step({$urandom, $urandom}, 1, 4'b0001, 4'b0000);
        chk("vdrop.noerr2", e2, 0);
        step({$urandom, $urandom}, 1, 4'b0000, 4'b0000);
        chk("vdrop.valid", v2, 1);
        chk("vdrop.cnt", c2, 3);

        step({$urandom, $urandom}, 1, 4'b0001, 4'b0001);
        step({$urandom, $urandom}, 1, 4'b0000, 4'b0000);
        chk("somf.flag", m2, 1);
        chk("somf.valid", v2, 1);

        step({$urandom, $urandom}, 1, 4'b0100, 4'b0000);
        chk("missof.err1", e1, 1);
        chk("missof.err2", e2, 1);
        step({$urandom, $urandom}, 1, 4'b0000, 4'b0000);
        chk("missof.idle", e2, 0);

        step({$urandom, $urandom}, 1, 4'b0001, 4'b0000);
        #2;
        rst = 1;
        model_reset();
        #1;
        chk("arst.s1", s1, 0);  chk("arst.s2", s2, 0);
        chk("arst.c1", c1, 0);  chk("arst.c2", c2, 0);
        @(posedge clk);
        #1;
        rst = 0;
        step({$urandom, $urandom}, 1, 4'b0000, 4'b0000);
        chk("arst.idle_noerr", e2, 0);
        chk("arst.idle_novalid", v2, 0);

        ph = 0;
        for (int k = 0; k < 3000; k++) begin
            logic [3:0] sf, sm;
            logic vv;
            vv = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 3) != 0) sf = {3'b000, ph};
            else sf = {3'b000, 1'($urandom_range(0, 1))};
            sm = {3'b000, 1'($urandom_range(0, 3) == 0)};
            if ($urandom_range(0, 49) == 0) sf[1 + $urandom_range(0, 2)] = 1'b1;
            if ($urandom_range(0, 49) == 0) sm[1 + $urandom_range(0, 2)] = 1'b1;
            if (vv) ph = ~ph;
            step({$urandom, $urandom}, vv, sf, sm);
        end

        @(negedge clk);
        run = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
